// File: rtl/write_back.sv
`default_nettype none
// ============================================================================
//  Module   : write_back
//  Purpose  : Final (write-back) stage of the hybrid ARM/MIPS pipeline.
//             Selects the register-file write data (ALU result, data-memory
//             read, secondary-memory read or I/O input) and registers it
//             together with the destination register and control flags.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             PCSrc, RegWrite     - control flags from the previous stage
//             IOFlag              - force IOIn as write data (optional)
//             MemToReg[1:0]       - write-data select
//             IOIn, ReadData,
//             ReadDataP, ALUOut   - candidate write-data words
//             Rd                  - destination register id (carried as-is)
//             OutData, RdOut,
//             PCSrcOut,
//             RegWriteOut         - registered outputs, 1-cycle latency
//  Config   : WB_IO_OVERRIDE_EN - when defined, IOFlag=1 selects IOIn
//             regardless of MemToReg; otherwise IOFlag is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module write_back #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCSrc,
  input  logic              RegWrite,
  input  logic              IOFlag,
  input  logic [1:0]        MemToReg,
  input  logic [DATA_W-1:0] IOIn,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ReadDataP,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] Rd,
  output logic [DATA_W-1:0] OutData,
  output logic [DATA_W-1:0] RdOut,
  output logic              PCSrcOut,
  output logic              RegWriteOut
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_MEMP = 2'b10;
  localparam logic [1:0] SEL_IO   = 2'b11;

  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic [DATA_W-1:0] rd_out_d,   rd_out_q;
  logic              pc_src_d,   pc_src_q;
  logic              reg_write_d, reg_write_q;
  logic [DATA_W-1:0] mux_data;

  // Write-data selection; illegal/unknown selects fall back to the ALU result.
  always_comb begin
    mux_data = ALUOut;
    case (MemToReg)
      SEL_ALU:  mux_data = ALUOut;
      SEL_MEM:  mux_data = ReadData;
      SEL_MEMP: mux_data = ReadDataP;
      SEL_IO:   mux_data = IOIn;
      default:  mux_data = ALUOut;
    endcase
  end

`ifdef WB_IO_OVERRIDE_EN
  // I/O override wins over the MemToReg select.
  always_comb begin
    out_data_d = mux_data;
    if (IOFlag) begin
      out_data_d = IOIn;
    end
  end
`else
  // IOFlag is kept on the port list for interface compatibility only.
  logic unused_ioflag;
  assign unused_ioflag = IOFlag;

  always_comb begin
    out_data_d = mux_data;
  end
`endif

  // Sideband values pass straight through; no gating between signals.
  always_comb begin
    rd_out_d    = Rd;
    pc_src_d    = PCSrc;
    reg_write_d = RegWrite;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      rd_out_q    <= '0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      rd_out_q    <= rd_out_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign OutData     = out_data_q;
  assign RdOut       = rd_out_q;
  assign PCSrcOut    = pc_src_q;
  assign RegWriteOut = reg_write_q;

endmodule
`default_nettype wire

// File: tb/tb_write_back.sv
`default_nettype none
// ============================================================================
//  Module   : tb_write_back
//  Purpose  : Self-checking bench for write_back: directed scenarios followed
//             by randomized traffic compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc, RegWrite, IOFlag;
  logic [1:0]  MemToReg;
  logic [31:0] IOIn, ReadData, ReadDataP, ALUOut, Rd;
  logic [31:0] OutData, RdOut;
  logic        PCSrcOut, RegWriteOut;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what the outputs should currently show.
  logic [31:0] exp_data, exp_rd;
  logic        exp_pc, exp_rw;

  always #5 clk = ~clk;

  write_back #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .IOFlag     (IOFlag),
    .MemToReg   (MemToReg),
    .IOIn       (IOIn),
    .ReadData   (ReadData),
    .ReadDataP  (ReadDataP),
    .ALUOut     (ALUOut),
    .Rd         (Rd),
    .OutData    (OutData),
    .RdOut      (RdOut),
    .PCSrcOut   (PCSrcOut),
    .RegWriteOut(RegWriteOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Behavioural reference: pick the candidate word by select index.
  function automatic logic [31:0] ref_data();
    logic [31:0] src [4];
    src[0] = ALUOut; src[1] = ReadData; src[2] = ReadDataP; src[3] = IOIn;
`ifdef WB_IO_OVERRIDE_EN
    if (IOFlag) return IOIn;
`endif
    return src[int'(MemToReg)];
  endfunction

  task automatic set_common();
    IOIn = 32'h3C; ReadData = 32'h55; ReadDataP = 32'h7F; ALUOut = 32'h16; Rd = 32'hE6;
  endtask

  task automatic drive(input logic r, input logic [1:0] sel, input logic pc,
                       input logic rw, input logic iof);
    rst = r; MemToReg = sel; PCSrc = pc; RegWrite = rw; IOFlag = iof;
  endtask

  // Outputs must still hold old values before the edge, new values after it.
  task automatic step(input string tag);
    #1;
    check({tag, "_hold"}, OutData, exp_data);
    if (rst) begin
      exp_data = '0; exp_rd = '0; exp_pc = 1'b0; exp_rw = 1'b0;
    end else begin
      exp_data = ref_data(); exp_rd = Rd; exp_pc = PCSrc; exp_rw = RegWrite;
    end
    @(posedge clk); #1;
    check({tag, "_data"}, OutData, exp_data);
    check({tag, "_rd"},   RdOut,   exp_rd);
    check({tag, "_pc"},   {31'b0, PCSrcOut},    {31'b0, exp_pc});
    check({tag, "_rw"},   {31'b0, RegWriteOut}, {31'b0, exp_rw});
    @(negedge clk);
  endtask

  initial begin
    set_common();
    drive(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    exp_data = 'x; exp_rd = 'x; exp_pc = 1'bx; exp_rw = 1'bx;
    @(negedge clk);
    // Reset: hold check is meaningless before the first edge, so go direct.
    @(posedge clk); #1;
    check("reset_data", OutData, 32'h0);
    check("reset_rd",   RdOut,   32'h0);
    check("reset_pc",   {31'b0, PCSrcOut},    32'h0);
    check("reset_rw",   {31'b0, RegWriteOut}, 32'h0);
    exp_data = '0; exp_rd = '0; exp_pc = 1'b0; exp_rw = 1'b0;
    @(negedge clk);

    // Directed scenarios with literal expectations.
    drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b0); step("dmem");
    check("dmem_lit", OutData, 32'h55);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); step("alu");
    check("alu_lit", OutData, 32'h16);
    drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0); step("memp");
    check("memp_lit", OutData, 32'h7F);
    drive(1'b0, 2'b11, 1'b1, 1'b1, 1'b0); step("io");
    check("io_lit", OutData, 32'h3C);
    check("io_flags", {30'b0, PCSrcOut, RegWriteOut}, 32'h3);
    drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b1); step("ovr");
`ifdef WB_IO_OVERRIDE_EN
    check("ovr_lit", OutData, 32'h3C);
`else
    check("ovr_lit", OutData, 32'h55);
`endif
    drive(1'b0, 2'b00, 1'b1, 1'b1, 1'b0); step("pre_rst");
    drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b0); step("mid_rst");
    check("mid_rst_lit", OutData | RdOut, 32'h0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); step("post_rst");
    check("post_rst_lit", OutData, 32'h16);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      IOIn = $urandom; ReadData = $urandom; ReadDataP = $urandom;
      ALUOut = $urandom; Rd = $urandom;
      drive(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
